// File: rtl/fdtd_prod_accum.sv
// ============================================================================
// fdtd_prod_accum
//
// Purpose:
//   Back end of the FDTD ALU multiplier. Each signed 2*WIDTH-bit fixed-point
//   product is rounded (half up) and shifted right by FRAC. The result is
//   then saturated into a guarded accumulator word. A framed run of such
//   terms is summed, which gives one FDTD update (sum of coeff*field). Each
//   frame produces one saturated WIDTH-bit result and a sticky flag that is
//   set if any clipping happened anywhere in the frame.
//
// Pipeline:
//   stage 1 : round, shift and saturate the product to ACC_W bits
//   stage 2 : accumulate; on the last term, emit the frame result
//   The term with p_last_i captured at edge t gives q_valid_o during t+2.
//
// Ports:
//   clk_i      in   1        clock, rising edge
//   rst_ni     in   1        asynchronous reset, active-low
//   clr_i      in   1        synchronous abort of the in-flight term and partial sum
//   p_valid_i  in   1        p_i carries a valid product this cycle
//   p_last_i   in   1        with p_valid_i: final term of the current frame
//   p_i        in   2*WIDTH  signed product from the multiplier
//   q_valid_o  out  1        one-cycle pulse: q_o/q_sat_o hold a new frame result
//   q_o        out  WIDTH    signed saturated frame sum (held between frames)
//   q_sat_o    out  1        saturation occurred somewhere in that frame (held)
//   busy_o     out  1        frame open or a term in flight
// ============================================================================
module fdtd_prod_accum #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int GUARD = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               p_valid_i,
    input  logic               p_last_i,
    input  logic [2*WIDTH-1:0] p_i,
    output logic               q_valid_o,
    output logic [WIDTH-1:0]   q_o,
    output logic               q_sat_o,
    output logic               busy_o
);

    localparam int PW     = 2 * WIDTH;
    localparam int ACC_W  = WIDTH + GUARD;
    localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;

    // This is the half-LSB rounding constant. It is zero when FRAC is 0,
    // because then nothing is shifted out and no rounding is needed.
    localparam logic [PW:0] RND = (FRAC > 0) ? ({{PW{1'b0}}, 1'b1} << RND_SH) : '0;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [WIDTH-1:0] Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // ------------------------------------------------------------------------
    // Stage 1 datapath
    // ------------------------------------------------------------------------
    logic signed [PW:0]      pExt;
    logic signed [PW:0]      pRnd;
    logic signed [PW:0]      pShr;
    logic [PW-ACC_W+1:0]     pHdr;
    logic                    pFits;

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_last_q,  s1_last_d;
    logic                    s1_sat_q,   s1_sat_d;
    logic [ACC_W-1:0]        s1_data_q,  s1_data_d;

    // The product is widened by one bit before the rounding constant is
    // added. This keeps the add from wrapping when the product is at the
    // top of the positive range.
    always_comb begin
        pExt = $signed({p_i[PW-1], p_i});
        pRnd = pExt + $signed(RND);
        pShr = pRnd >>> FRAC;
    end

    // The value fits in ACC_W bits when every bit from ACC_W-1 upward is a
    // copy of the sign bit.
    always_comb begin
        pHdr  = pShr[PW:ACC_W-1];
        pFits = (&pHdr) | (~|pHdr);
    end

    // Stage 1 captures only on p_valid_i. A p_last_i without a valid product
    // is ignored, so it can never close a frame. clr_i drops a product that
    // arrives in the same cycle.
    always_comb begin
        s1_valid_d = p_valid_i & ~clr_i;
        s1_last_d  = p_valid_i & p_last_i;
        s1_sat_d   = s1_sat_q;
        s1_data_d  = s1_data_q;
        if (p_valid_i) begin
            s1_sat_d  = ~pFits;
            s1_data_d = pFits ? pShr[ACC_W-1:0] : (pShr[PW] ? ACC_MIN : ACC_MAX);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sat_q   <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_sat_q   <= s1_sat_d;
            s1_data_q  <= s1_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: accumulator and frame control
    // ------------------------------------------------------------------------
    logic [0:0]              state_q, state_d;
    logic [ACC_W-1:0]        acc_q,   acc_d;
    logic                    sticky_q, sticky_d;
    logic                    q_valid_q, q_valid_d;
    logic [WIDTH-1:0]        q_q,     q_d;
    logic                    q_sat_q, q_sat_d;

    logic [ACC_W-1:0]        base;
    logic [ACC_W:0]          sum;
    logic                    accClip;
    logic [ACC_W-1:0]        accSat;
    logic [ACC_W-WIDTH+1:0]  qHdr;
    logic                    qClip;
    logic [WIDTH-1:0]        qSatVal;
    logic                    frameSat;

    // In IDLE the first term starts from zero. The old acc value is ignored
    // there, which gives back-to-back frames without a bubble and without
    // clearing acc.
    always_comb begin
        base     = (state_q == ST_IDLE) ? '0 : acc_q;
        sum      = {base[ACC_W-1], base} + {s1_data_q[ACC_W-1], s1_data_q};
        accClip  = sum[ACC_W] ^ sum[ACC_W-1];
        accSat   = accClip ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
        qHdr     = sum[ACC_W:WIDTH-1];
        qClip    = ~((&qHdr) | (~|qHdr));
        qSatVal  = qClip ? (sum[ACC_W] ? Q_MIN : Q_MAX) : sum[WIDTH-1:0];
        frameSat = sticky_q | s1_sat_q | accClip | qClip;
    end

    // Frame FSM. clr_i has priority over a term in stage 1. It aborts the
    // frame and leaves the last published q_o/q_sat_o unchanged.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        q_valid_d = 1'b0;
        q_d       = q_q;
        q_sat_d   = q_sat_q;
        if (clr_i) begin
            state_d  = ST_IDLE;
            sticky_d = 1'b0;
        end else if (s1_valid_q) begin
            acc_d = accSat;
            if (s1_last_q) begin
                state_d   = ST_IDLE;
                sticky_d  = 1'b0;
                q_valid_d = 1'b1;
                q_d       = qSatVal;
                q_sat_d   = frameSat;
            end else begin
                state_d  = ST_ACCUM;
                sticky_d = sticky_q | s1_sat_q | accClip;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            q_valid_q <= 1'b0;
            q_q       <= '0;
            q_sat_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
            q_valid_q <= q_valid_d;
            q_q       <= q_d;
            q_sat_q   <= q_sat_d;
        end
    end

    assign q_valid_o = q_valid_q;
    assign q_o       = q_q;
    assign q_sat_o   = q_sat_q;
    assign busy_o    = (state_q == ST_ACCUM) | s1_valid_q;

endmodule

// File: tb/tb_fdtd_prod_accum.sv
// ============================================================================
// tb_fdtd_prod_accum
//
// Purpose:
//   Directed bench for fdtd_prod_accum with WIDTH=32, FRAC=16, GUARD=4.
//   The expected values are worked out by hand from the Q16 arithmetic.
//   Inputs are driven on the falling edge, and outputs are sampled on the
//   falling edge, away from the rising edge where the DUT updates.
// ============================================================================
module tb_fdtd_prod_accum;

    logic        clk_i;
    logic        rst_ni;
    logic        clr_i;
    logic        p_valid_i;
    logic        p_last_i;
    logic [63:0] p_i;
    logic        q_valid_o;
    logic [31:0] q_o;
    logic        q_sat_o;
    logic        busy_o;

    int total;
    int bad;
    int pulseCount;

    logic [63:0] singleP   [4] = '{64'h8000, 64'h7FFF, -64'sh8000, -64'sh8001};
    logic [63:0] singleExp [4] = '{64'h1, 64'h0, 64'h0, 64'hFFFF_FFFF};

    fdtd_prod_accum #(.WIDTH(32), .FRAC(16), .GUARD(4)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clr_i),
        .p_valid_i (p_valid_i),
        .p_last_i  (p_last_i),
        .p_i       (p_i),
        .q_valid_o (q_valid_o),
        .q_o       (q_o),
        .q_sat_o   (q_sat_o),
        .busy_o    (busy_o)
    );

    // Free-running 10-unit clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Counts every cycle where q_valid_o is high, so that each test can
    // check that exactly one pulse was seen per frame.
    always @(negedge clk_i) begin
        if (q_valid_o) pulseCount++;
    end

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Waits for a falling edge, then drives one cycle of inputs.
    task automatic applyStimulus(input logic valid, input logic last, input logic [63:0] p,
                                 input logic clr = 1'b0);
        @(negedge clk_i);
        p_valid_i = valid;
        p_last_i  = last;
        p_i       = p;
        clr_i     = clr;
    endtask

    // Call this right after the last term has been driven. The result must
    // appear on the second falling edge after that, as one single pulse.
    task automatic expectResult(input string tag, input logic [31:0] q, input logic sat);
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput({tag, " qv early"}, {63'h0, q_valid_o}, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput({tag, " qv"},  {63'h0, q_valid_o}, 64'h1);
        checkOutput({tag, " q"},   {32'h0, q_o}, {32'h0, q});
        checkOutput({tag, " sat"}, {63'h0, q_sat_o}, {63'h0, sat});
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput({tag, " qv drop"}, {63'h0, q_valid_o}, 64'h0);
        checkOutput({tag, " busy"},    {63'h0, busy_o}, 64'h0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        pulseCount = 0;
        rst_ni     = 1'b0;
        clr_i      = 1'b0;
        p_valid_i  = 1'b0;
        p_last_i   = 1'b0;
        p_i        = '0;

        // Reset state
        #12;
        checkOutput("rst qv",   {63'h0, q_valid_o}, 64'h0);
        checkOutput("rst q",    {32'h0, q_o}, 64'h0);
        checkOutput("rst sat",  {63'h0, q_sat_o}, 64'h0);
        checkOutput("rst busy", {63'h0, busy_o}, 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Test 1: 1.5 + 2.25 - 0.75 = 3.0
        applyStimulus(1'b0, 1'b0, 64'h0);
        pulseCount = 0;
        applyStimulus(1'b1, 1'b0, 64'h1_8000_0000);
        applyStimulus(1'b1, 1'b0, 64'h2_4000_0000);
        checkOutput("t1 busy", {63'h0, busy_o}, 64'h1);
        applyStimulus(1'b1, 1'b1, -64'sh0000_0000_C000_0000);
        expectResult("t1", 32'h0003_0000, 1'b0);
        checkOutput("t1 pulses", pulseCount, 64'd1);

        // Test 2: single-term frames exercising round half up
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, singleP[i]);
            expectResult($sformatf("t2.%0d", i), singleExp[i][31:0], 1'b0);
        end

        // Test 3: WIDTH clip in the final sum; next frame clears the sticky flag
        applyStimulus(1'b1, 1'b0, 64'h4000_0000_0000);
        applyStimulus(1'b1, 1'b1, 64'h4000_0000_0000);
        expectResult("t3a", 32'h7FFF_FFFF, 1'b1);
        applyStimulus(1'b1, 1'b1, 64'h1_0000_0000);
        expectResult("t3b", 32'h0001_0000, 1'b0);

        // Stage-1 clip at both extremes of the product range
        applyStimulus(1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF);
        expectResult("clip+", 32'h7FFF_FFFF, 1'b1);
        applyStimulus(1'b1, 1'b1, 64'h8000_0000_0000_0000);
        expectResult("clip-", 32'h8000_0000, 1'b1);

        // Test 6: async reset mid-frame, then 0.5 + 0.5
        applyStimulus(1'b1, 1'b0, 64'h3_0000_0000);
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput("t6 busy pre", {63'h0, busy_o}, 64'h1);
        rst_ni = 1'b0;
        #1;
        checkOutput("t6 q",    {32'h0, q_o}, 64'h0);
        checkOutput("t6 sat",  {63'h0, q_sat_o}, 64'h0);
        checkOutput("t6 qv",   {63'h0, q_valid_o}, 64'h0);
        checkOutput("t6 busy", {63'h0, busy_o}, 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(1'b1, 1'b0, 64'h8000_0000);
        applyStimulus(1'b1, 1'b1, 64'h8000_0000);
        expectResult("t6", 32'h0001_0000, 1'b0);

        // Test 4: CLR aborts the frame and drops the product that arrives with it
        pulseCount = 0;
        applyStimulus(1'b1, 1'b0, 64'h5_0000_0000);
        applyStimulus(1'b1, 1'b0, 64'h5_0000_0000);
        applyStimulus(1'b1, 1'b1, 64'h7_0000_0000, 1'b1);
        applyStimulus(1'b1, 1'b1, 64'h1_0000_0000);
        checkOutput("t4 busy clr", {63'h0, busy_o}, 64'h0);
        expectResult("t4", 32'h0001_0000, 1'b0);
        checkOutput("t4 pulses", pulseCount, 64'd1);

        // Test 5: back-to-back single-term frames
        pulseCount = 0;
        applyStimulus(1'b1, 1'b1, 64'h1_0000_0000);
        applyStimulus(1'b1, 1'b1, 64'h2_0000_0000);
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput("t5a qv", {63'h0, q_valid_o}, 64'h1);
        checkOutput("t5a q",  {32'h0, q_o}, 64'h1_0000);
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput("t5b qv", {63'h0, q_valid_o}, 64'h1);
        checkOutput("t5b q",  {32'h0, q_o}, 64'h2_0000);
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput("t5 qv drop", {63'h0, q_valid_o}, 64'h0);
        checkOutput("t5 pulses", pulseCount, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
